ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Two-host round-robin arbiter in front of one port of the dual-port data RAM. Grants one host request per cycle onto the RAM port and range-checks the address: in-range accesses go to the RAM, out-of-range accesses are answered locally with an error. Routes the RAM's 1-cycle response back to the granted host. Instantiated once per RAM port, e.g. core LSU plus debug/DMA host sharing port B.

## Interface
- BaseAddr, 32'h0010_0000, byte address of RAM word 0
- Depth, 128, RAM depth in 32-bit words; power of two; must equal the RAM's Depth
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- h_req_i  in  [1:0]  per-host request; held until granted
- h_we_i  in  [1:0]  per-host write enable
- h_be_i  in  [1:0][3:0]  per-host byte enables
- h_addr_i  in  [1:0][31:0]  per-host byte address
- h_wdata_i  in  [1:0][31:0]  per-host write data
- h_gnt_o  out  [1:0]  grant, combinational, one-hot or zero
- h_rvalid_o  out  [1:0]  response valid, one-hot or zero
- h_rdata_o  out  [1:0][31:0]  response data
- h_err_o  out  [1:0]  response error, qualified by h_rvalid_o
- dev_req_o, dev_we_o  out  1 each  RAM port request / write
- dev_be_o  out  4  RAM byte enables
- dev_addr_o, dev_wdata_o  out  32 each  RAM byte address / write data
- dev_rvalid_i  in  1  RAM response valid
- dev_rdata_i  in  32  RAM read data
- err_cnt_o  out  16  saturating count of out-of-range accesses

## Operation
- Arbitration: if exactly one host requests, it is granted. If both request, the host not granted last is granted. The priority pointer `last_q` updates only on a grant. Its reset value makes host 0 win the first tie.
- Range check: in_range = (addr − BaseAddr) < Depth*4, computed in 32-bit unsigned arithmetic, so addresses below BaseAddr wrap and fail the check. addr[1:0] is ignored.
- In-range grant: dev_req_o=1 and dev_we/be/addr/wdata are taken from the granted host. dev_addr_o = addr − BaseAddr.
- Out-of-range grant: dev_req_o=0 and the write has no effect. The arbiter sets `err_pend_q` and the owner is recorded.
- Response tracking: registers `pend_q`, `owner_q` and `err_pend_q` are loaded on every grant and cleared otherwise.
- In-range response: when dev_rvalid_i=1, h_rvalid_o[owner_q]=1, h_rdata_o[owner_q]=dev_rdata_i and h_err_o=0.
- Error response: when err_pend_q=1, h_rvalid_o[owner_q]=1, h_rdata_o=0 and h_err_o=1.
- Non-owner outputs: rdata is driven to 0 on every non-owner host.
- err_cnt_o increments by 1 per out-of-range grant and saturates at 16'hFFFF.
- Write responses: writes also return rvalid, with rdata undefined for in-range writes. Hosts ignore that rdata.

## Timing
- Grant is combinational in the request cycle. The response arrives exactly 1 cycle later for both RAM and error paths.
- One grant per cycle. Back-to-back grants are allowed: the response to grant N and grant N+1 appear in the same cycle pair.
- Simultaneous request and response in one cycle is normal operation. The registers for the new grant overwrite the old ones at the clock edge.
- Reset values: h_rvalid_o=0, h_err_o=0, h_rdata_o=0, err_cnt_o=0, dev_req_o=0. Registers: pend_q=0, err_pend_q=0, last_q=host 1.
- Reset asserted mid-transaction: the pending response is dropped. A dev_rvalid_i arriving while pend_q=0 is ignored, and an assertion flags it.
- Assertions:
  - h_gnt_o is one-hot or zero.
  - dev_rvalid_i equals pend_q & ~err_pend_q delayed from the grant.
  - A host never sees a grant without its request.

## Structure
- Package `ram_arb_pkg`:
  - `host_id_t` (1-bit)
  - `host_req_t` struct (we, be, addr, wdata)
  - `rsp_t` struct (rdata, err)
  - `NumHosts = 2`
- Sub-module `ram_arb_rr`: 2-way round-robin arbiter holding `last_q`. Inputs req[1:0]; outputs gnt[1:0] and gnt_id.
- Top module contains the range check, mux, response tracking and counter. Estimated 150–220 lines.

## Test plan
- Host 0 alone writes 32'hDEADBEEF, be 4'hF, to BaseAddr+8, then reads the same address. Required: gnt same cycle, dev_addr_o=8, read rvalid[0] 1 cycle later with rdata DEADBEEF and err=0.
- Both hosts request continuously for 6 cycles from reset. Required: grants alternate 0,1,0,1,0,1, and each rvalid is routed to the correct host 1 cycle after its grant.
- Host 1 reads BaseAddr+Depth*4. Required: dev_req_o=0, rvalid[1]=1 with err=1 and rdata=0 the next cycle, err_cnt_o=1.
- Host 0 reads BaseAddr−4 (wrap case). Required: error response and no RAM request.
- Partial write with be=4'b0101, then a read. Required: only bytes 0 and 2 are updated. Back-to-back reads across both hosts produce no gap cycles.
- RST_N asserted in the cycle after a grant. Required: no h_rvalid_o, all outputs at reset values, and host 0 wins the first tie after release.

Source files
------------

// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// ram_arb_pkg
// Shared types and helpers for the two-host RAM port arbiter.
// Revision: 1.0
// ============================================================================
package ram_arb_pkg;

   localparam int NumHosts = 2;

   typedef logic host_id_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } host_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   // Unsigned wrap makes addresses below the base fail the check.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] span_bytes);
      return (addr - base) < span_bytes;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter_if
// Host-side and RAM-side bus signals of the RAM port arbiter.
// Revision: 1.0
// ============================================================================
interface ram_port_arbiter_if;
   import ram_arb_pkg::*;

   logic [NumHosts-1:0]        h_req_i;
   logic [NumHosts-1:0]        h_we_i;
   logic [NumHosts-1:0][3:0]   h_be_i;
   logic [NumHosts-1:0][31:0]  h_addr_i;
   logic [NumHosts-1:0][31:0]  h_wdata_i;
   logic [NumHosts-1:0]        h_gnt_o;
   logic [NumHosts-1:0]        h_rvalid_o;
   logic [NumHosts-1:0][31:0]  h_rdata_o;
   logic [NumHosts-1:0]        h_err_o;

   logic                       dev_req_o;
   logic                       dev_we_o;
   logic [3:0]                 dev_be_o;
   logic [31:0]                dev_addr_o;
   logic [31:0]                dev_wdata_o;
   logic                       dev_rvalid_i;
   logic [31:0]                dev_rdata_i;

   modport slave (
      input  h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
      input  dev_rvalid_i, dev_rdata_i,
      output h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
      output dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
   );

   modport master (
      output h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
      output dev_rvalid_i, dev_rdata_i,
      input  h_gnt_o, h_rvalid_o, h_rdata_o, h_err_o,
      input  dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
   );

endinterface
`default_nettype wire

// File: rtl/ram_arb_rr.sv
`default_nettype none
// ============================================================================
// ram_arb_rr
// Two-way round-robin arbiter; last_q remembers the most recent winner.
// Revision: 1.0
// ============================================================================
module ram_arb_rr
   import ram_arb_pkg::*;
(
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [NumHosts-1:0] req_i,
   output logic [NumHosts-1:0] gnt_o,
   output host_id_t            gnt_id_o
);

   host_id_t last_q, last_d;

   always_comb begin
      gnt_id_o = 1'b0;
      if (&req_i) begin
         gnt_id_o = ~last_q;
      end else if (req_i[1]) begin
         gnt_id_o = 1'b1;
      end
      gnt_o = '0;
      if (|req_i) begin
         gnt_o[gnt_id_o] = 1'b1;
      end
      last_d = (|req_i) ? gnt_id_o : last_q;
   end

   // Reset to host 1 so host 0 wins the first tie.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// ram_port_arbiter
// Round-robin host arbiter with address range check in front of one RAM port.
// Revision: 1.0
// ============================================================================
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter logic [31:0] BaseAddr = 32'h0010_0000,
   parameter int unsigned Depth    = 128
) (
   input  logic              CLK,
   input  logic              RST_N,
   ram_port_arbiter_if.slave bus,
   output logic [15:0]       err_cnt_o
);

   localparam logic [31:0] c_SPAN_BYTES = 32'(Depth * 4);

   logic [NumHosts-1:0]       gnt;
   host_id_t                  gnt_id;
   host_req_t                 sel;
   logic [31:0]               dev_off;
   logic                      any_gnt, in_range, oor_gnt;

   logic                      pend_q, pend_d;
   logic                      err_pend_q, err_pend_d;
   host_id_t                  owner_q, owner_d;
   logic [15:0]               err_cnt_q, err_cnt_d;

   rsp_t                      rsp;
   logic                      rsp_valid;
   logic [NumHosts-1:0]       rsp_rvalid, rsp_err;
   logic [NumHosts-1:0][31:0] rsp_rdata;

   ram_arb_rr u_rr (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .req_i    (bus.h_req_i),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id)
   );

   always_comb begin
      sel.we    = bus.h_we_i[gnt_id];
      sel.be    = bus.h_be_i[gnt_id];
      sel.addr  = bus.h_addr_i[gnt_id];
      sel.wdata = bus.h_wdata_i[gnt_id];
      dev_off   = sel.addr - BaseAddr;
      in_range  = addr_in_range(sel.addr, BaseAddr, c_SPAN_BYTES);
      any_gnt   = |gnt;
      oor_gnt   = any_gnt & ~in_range;
   end

   assign bus.h_gnt_o     = gnt;
   assign bus.dev_req_o   = any_gnt & in_range;
   assign bus.dev_we_o    = sel.we;
   assign bus.dev_be_o    = sel.be;
   assign bus.dev_addr_o  = dev_off;
   assign bus.dev_wdata_o = sel.wdata;

   always_comb begin
      pend_d     = any_gnt;
      err_pend_d = oor_gnt;
      owner_d    = gnt_id;
      err_cnt_d  = err_cnt_q;
      if (oor_gnt && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pend_q     <= 1'b0;
         err_pend_q <= 1'b0;
         owner_q    <= 1'b0;
         err_cnt_q  <= 16'd0;
      end else begin
         pend_q     <= pend_d;
         err_pend_q <= err_pend_d;
         owner_q    <= owner_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // A stray RAM response with nothing pending never reaches a host.
   always_comb begin
      rsp_valid  = err_pend_q | (pend_q & bus.dev_rvalid_i);
      rsp.rdata  = err_pend_q ? 32'd0 : bus.dev_rdata_i;
      rsp.err    = err_pend_q;
      rsp_rvalid = '0;
      rsp_err    = '0;
      rsp_rdata  = '0;
      for (int h = 0; h < NumHosts; h++) begin
         if (rsp_valid && (owner_q == host_id_t'(h))) begin
            rsp_rvalid[h] = 1'b1;
            rsp_err[h]    = rsp.err;
            rsp_rdata[h]  = rsp.rdata;
         end
      end
   end

   assign bus.h_rvalid_o = rsp_rvalid;
   assign bus.h_err_o    = rsp_err;
   assign bus.h_rdata_o  = rsp_rdata;
   assign err_cnt_o      = err_cnt_q;

   ap_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST_N)
      $onehot0(gnt));
   ap_gnt_has_req: assert property (@(posedge CLK) disable iff (!RST_N)
      (gnt & ~bus.h_req_i) == '0);
   ap_rvalid_track: assert property (@(posedge CLK) disable iff (!RST_N)
      bus.dev_rvalid_i == (pend_q & ~err_pend_q));

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ram_port_arbiter
// Table-driven bench for ram_port_arbiter with a 1-cycle RAM model.
// Revision: 1.0
// ============================================================================
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   localparam logic [31:0] B = 32'h0010_0000;
   localparam logic [31:0] W = 32'hA5A5_A5A5;  // RAM-model rdata on writes

   typedef struct {
      logic [1:0]  req, we;
      logic [3:0]  be0, be1;
      logic [31:0] a0, a1, d0, d1;
      logic [1:0]  gnt;
      logic        dreq;
      logic [31:0] daddr;
      logic [1:0]  rv;
      logic [31:0] rd0, rd1;
      logic [1:0]  err;
      logic [15:0] ecnt;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [15:0] err_cnt;
   int          checks = 0;
   int          failures = 0;

   ram_port_arbiter_if bus();

   ram_port_arbiter #(.BaseAddr(B), .Depth(128)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .bus       (bus),
      .err_cnt_o (err_cnt)
   );

   always #5 CLK = ~CLK;

   logic [31:0] mem [128];
   logic        ram_rvalid = 1'b0;
   logic [31:0] ram_rdata = 32'd0;
   logic [6:0]  ram_idx;

   assign ram_idx          = bus.dev_addr_o[8:2];
   assign bus.dev_rvalid_i = ram_rvalid;
   assign bus.dev_rdata_i  = ram_rdata;

   always @(posedge CLK) begin
      ram_rvalid <= RST_N & bus.dev_req_o;
      if (RST_N && bus.dev_req_o) begin
         ram_rdata <= bus.dev_we_o ? W : mem[ram_idx];
         if (bus.dev_we_o) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.dev_be_o[b]) mem[ram_idx][b*8 +: 8] <= bus.dev_wdata_o[b*8 +: 8];
            end
         end
      end
   end

   function automatic vec_t mk(logic [1:0] req, we, logic [3:0] be0, be1,
                               logic [31:0] a0, a1, d0, d1, logic [1:0] gnt,
                               logic dreq, logic [31:0] daddr, logic [1:0] rv,
                               logic [31:0] rd0, rd1, logic [1:0] err, logic [15:0] ecnt);
      vec_t v;
      v.req = req; v.we = we; v.be0 = be0; v.be1 = be1;
      v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
      v.gnt = gnt; v.dreq = dreq; v.daddr = daddr; v.rv = rv;
      v.rd0 = rd0; v.rd1 = rd1; v.err = err; v.ecnt = ecnt;
      return v;
   endfunction

   function automatic vec_t idle(logic [1:0] rv, logic [31:0] rd0, rd1,
                                 logic [1:0] err, logic [15:0] ecnt);
      return mk(2'b00, 2'b00, 4'h0, 4'h0, 32'd0, 32'd0, 32'd0, 32'd0,
                2'b00, 1'b0, 32'd0, rv, rd0, rd1, err, ecnt);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.h_req_i      = v.req;
      bus.h_we_i       = v.we;
      bus.h_be_i[0]    = v.be0;
      bus.h_be_i[1]    = v.be1;
      bus.h_addr_i[0]  = v.a0;
      bus.h_addr_i[1]  = v.a1;
      bus.h_wdata_i[0] = v.d0;
      bus.h_wdata_i[1] = v.d1;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, " gnt"},     32'(bus.h_gnt_o),    32'(v.gnt));
      chk({tag, " dev_req"}, 32'(bus.dev_req_o),  32'(v.dreq));
      if (v.dreq) chk({tag, " dev_addr"}, bus.dev_addr_o, v.daddr);
      chk({tag, " rvalid"},  32'(bus.h_rvalid_o), 32'(v.rv));
      chk({tag, " rdata0"},  bus.h_rdata_o[0],    v.rd0);
      chk({tag, " rdata1"},  bus.h_rdata_o[1],    v.rd1);
      chk({tag, " err"},     32'(bus.h_err_o),    32'(v.err));
      chk({tag, " err_cnt"}, 32'(err_cnt),        32'(v.ecnt));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " rvalid"},  32'(bus.h_rvalid_o), 32'd0);
      chk({tag, " err"},     32'(bus.h_err_o),    32'd0);
      chk({tag, " rdata0"},  bus.h_rdata_o[0],    32'd0);
      chk({tag, " rdata1"},  bus.h_rdata_o[1],    32'd0);
      chk({tag, " err_cnt"}, 32'(err_cnt),        32'd0);
      chk({tag, " dev_req"}, 32'(bus.dev_req_o),  32'd0);
   endtask

   vec_t vecs [22];
   vec_t post [3];

   initial begin
      // Alternating ties from reset, then single-host, error, boundary and byte-enable cases.
      vecs[0]  = mk(2'b11, 2'b11, 4'hF, 4'hF, B+32'h10, B+32'h20, 32'h1111_1111, 32'h2222_2222, 2'b01, 1'b1, 32'h10, 2'b00, 32'd0, 32'd0, 2'b00, 16'd0);
      vecs[1]  = mk(2'b11, 2'b11, 4'hF, 4'hF, B+32'h14, B+32'h20, 32'h3333_3333, 32'h2222_2222, 2'b10, 1'b1, 32'h20, 2'b01, W, 32'd0, 2'b00, 16'd0);
      vecs[2]  = mk(2'b11, 2'b11, 4'hF, 4'hF, B+32'h14, B+32'h24, 32'h3333_3333, 32'h4444_4444, 2'b01, 1'b1, 32'h14, 2'b10, 32'd0, W, 2'b00, 16'd0);
      vecs[3]  = mk(2'b11, 2'b10, 4'hF, 4'hF, B+32'h10, B+32'h24, 32'd0, 32'h4444_4444, 2'b10, 1'b1, 32'h24, 2'b01, W, 32'd0, 2'b00, 16'd0);
      vecs[4]  = mk(2'b11, 2'b00, 4'hF, 4'hF, B+32'h10, B+32'h20, 32'd0, 32'd0, 2'b01, 1'b1, 32'h10, 2'b10, 32'd0, W, 2'b00, 16'd0);
      vecs[5]  = mk(2'b11, 2'b00, 4'hF, 4'hF, B+32'h14, B+32'h20, 32'd0, 32'd0, 2'b10, 1'b1, 32'h20, 2'b01, 32'h1111_1111, 32'd0, 2'b00, 16'd0);
      vecs[6]  = mk(2'b01, 2'b00, 4'hF, 4'hF, B+32'h14, 32'd0, 32'd0, 32'd0, 2'b01, 1'b1, 32'h14, 2'b10, 32'd0, 32'h2222_2222, 2'b00, 16'd0);
      vecs[7]  = mk(2'b10, 2'b00, 4'hF, 4'hF, 32'd0, B+32'h24, 32'd0, 32'd0, 2'b10, 1'b1, 32'h24, 2'b01, 32'h3333_3333, 32'd0, 2'b00, 16'd0);
      vecs[8]  = idle(2'b10, 32'd0, 32'h4444_4444, 2'b00, 16'd0);
      vecs[9]  = mk(2'b01, 2'b01, 4'hF, 4'hF, B+32'h8, 32'd0, 32'hDEAD_BEEF, 32'd0, 2'b01, 1'b1, 32'h8, 2'b00, 32'd0, 32'd0, 2'b00, 16'd0);
      vecs[10] = mk(2'b01, 2'b00, 4'hF, 4'hF, B+32'h8, 32'd0, 32'd0, 32'd0, 2'b01, 1'b1, 32'h8, 2'b01, W, 32'd0, 2'b00, 16'd0);
      vecs[11] = idle(2'b01, 32'hDEAD_BEEF, 32'd0, 2'b00, 16'd0);
      vecs[12] = mk(2'b10, 2'b00, 4'hF, 4'hF, 32'd0, B+32'h200, 32'd0, 32'd0, 2'b10, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00, 16'd0);
      vecs[13] = idle(2'b10, 32'd0, 32'd0, 2'b10, 16'd1);
      vecs[14] = mk(2'b01, 2'b00, 4'hF, 4'hF, B-32'h4, 32'd0, 32'd0, 32'd0, 2'b01, 1'b0, 32'd0, 2'b00, 32'd0, 32'd0, 2'b00, 16'd1);
      vecs[15] = mk(2'b10, 2'b10, 4'hF, 4'hF, 32'd0, B+32'h1FC, 32'd0, 32'h5555_5555, 2'b10, 1'b1, 32'h1FC, 2'b01, 32'd0, 32'd0, 2'b01, 16'd2);
      vecs[16] = mk(2'b01, 2'b00, 4'hF, 4'hF, B+32'h1FC, 32'd0, 32'd0, 32'd0, 2'b01, 1'b1, 32'h1FC, 2'b10, 32'd0, W, 2'b00, 16'd2);
      vecs[17] = idle(2'b01, 32'h5555_5555, 32'd0, 2'b00, 16'd2);
      vecs[18] = mk(2'b10, 2'b10, 4'hF, 4'b0101, 32'd0, B+32'h8, 32'd0, 32'hAABB_CCDD, 2'b10, 1'b1, 32'h8, 2'b00, 32'd0, 32'd0, 2'b00, 16'd2);
      vecs[19] = mk(2'b11, 2'b00, 4'hF, 4'hF, B+32'h8, B+32'h8, 32'd0, 32'd0, 2'b01, 1'b1, 32'h8, 2'b10, 32'd0, W, 2'b00, 16'd2);
      vecs[20] = mk(2'b10, 2'b00, 4'hF, 4'hF, 32'd0, B+32'h8, 32'd0, 32'd0, 2'b10, 1'b1, 32'h8, 2'b01, 32'hDEBB_BEDD, 32'd0, 2'b00, 16'd2);
      vecs[21] = idle(2'b10, 32'd0, 32'hDEBB_BEDD, 2'b00, 16'd2);

      // After the mid-transaction reset: host 0 must win the first tie again.
      post[0]  = mk(2'b11, 2'b00, 4'hF, 4'hF, B+32'h8, B+32'h8, 32'd0, 32'd0, 2'b01, 1'b1, 32'h8, 2'b00, 32'd0, 32'd0, 2'b00, 16'd0);
      post[1]  = mk(2'b10, 2'b00, 4'hF, 4'hF, 32'd0, B+32'h8, 32'd0, 32'd0, 2'b10, 1'b1, 32'h8, 2'b01, 32'hDEBB_BEDD, 32'd0, 2'b00, 16'd0);
      post[2]  = idle(2'b10, 32'd0, 32'hDEBB_BEDD, 2'b00, 16'd0);

      RST_N = 1'b0;
      drive(idle(2'b00, 32'd0, 32'd0, 2'b00, 16'd0));
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      #1;
      check_reset("reset");
      RST_N = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge CLK);
         drive(vecs[i]);
         #1;
         check_vec($sformatf("v%0d", i), vecs[i]);
      end

      // Grant a read, then reset before its response is delivered.
      @(negedge CLK);
      drive(mk(2'b01, 2'b00, 4'hF, 4'hF, B+32'h8, 32'd0, 32'd0, 32'd0, 2'b01, 1'b1, 32'h8, 2'b00, 32'd0, 32'd0, 2'b00, 16'd2));
      #1;
      chk("rst_grant gnt", 32'(bus.h_gnt_o), 32'd1);
      chk("rst_grant dev_req", 32'(bus.dev_req_o), 32'd1);
      @(negedge CLK);
      drive(idle(2'b00, 32'd0, 32'd0, 2'b00, 16'd0));
      RST_N = 1'b0;
      #1;
      check_reset("rst_mid");
      @(negedge CLK);
      #1;
      check_reset("rst_hold");
      RST_N = 1'b1;
      @(negedge CLK);
      #1;
      chk("post_rst rvalid", 32'(bus.h_rvalid_o), 32'd0);

      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         drive(post[i]);
         #1;
         check_vec($sformatf("p%0d", i), post[i]);
      end

      @(negedge CLK);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
